// File: rtl/timer_pkg.sv
// Shared types and register map for the timer_array block.
// Optional prescaler is enabled with TIMER_ARRAY_PRESCALE_EN.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // Register index within a channel (byte offset >> 2)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_PSC    = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PEND = 4;

endpackage

// File: rtl/timer_array_if.sv
// Bridge bus as seen by the timer window: address, write strobe/data, read data.
interface timer_array_if;
  logic [31:0] PrAddr;
  logic        PrWe;
  logic [31:0] PrWD;
  logic [31:0] PrRD;

  modport master (output PrAddr, PrWe, PrWD, input PrRD);
  modport slave  (input PrAddr, PrWe, PrWD, output PrRD);
endinterface

// File: rtl/timer_channel.sv
// One down-counting timer: CTRL/PRESET/COUNT registers, FSM and interrupt.
// TIMER_ARRAY_PRESCALE_EN adds an 8-bit PSC register and prescale counter.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_we,
  input  logic        preset_we,
`ifdef TIMER_ARRAY_PRESCALE_EN
  input  logic        psc_we,
`endif
  input  logic [31:0] wd,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic [31:0] psc_rd,
  output logic        irq
);

  state_t           state;
  logic             en, im, pend;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset, count;
  logic             tick;

`ifdef TIMER_ARRAY_PRESCALE_EN
  logic [7:0] psc, psc_cnt;

  assign tick   = (psc_cnt == psc);
  assign psc_rd = {24'd0, psc};

  always_ff @(posedge clk) begin
    if (reset) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else begin
      if (psc_we) psc <= wd[7:0];
      if (state == S_LOAD) psc_cnt <= '0;
      else if (state == S_CNT) psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick   = 1'b1;
  assign psc_rd = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      if (preset_we) preset <= wd[CNT_W-1:0];
      case (state)
        S_IDLE: if (en) state <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) state <= S_IDLE;
          else if (count == '0) begin
            state <= S_INT;
            pend  <= 1'b1;
          end else if (tick) count <= count - CNT_W'(1);
        end
        S_INT: begin
          // Reserved modes behave as one-shot
          if (mode == MODE_RELOAD) begin
            state <= S_LOAD;
            pend  <= 1'b0;
          end else begin
            state <= S_IDLE;
            en    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A CTRL write overrides whatever the FSM did to EN/pend this edge
      if (ctrl_we) begin
        en   <= wd[CTRL_EN];
        mode <= wd[CTRL_MODE +: 2];
        im   <= wd[CTRL_IM];
        pend <= 1'b0;
      end
    end
  end

  assign ctrl_rd   = {27'd0, pend, im, mode, en};
  assign preset_rd = 32'(preset);
  assign count_rd  = 32'(count);
  assign irq       = pend & im;

endmodule

// File: rtl/timer_array.sv
// Bank of N_CH memory-mapped timers: address decode, read mux, HWInt lines.
// Build with TIMER_ARRAY_PRESCALE_EN to add the per-channel PSC register.
module timer_array
  import timer_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic               clk,
  input  logic               reset,
  timer_array_if.slave       bus,
  output logic [N_CH-1:0]    HWInt
);

  logic [31:0] off;
  logic        in_win;
  logic [27:0] ch_sel;
  logic [1:0]  reg_sel;

  // Unsigned wrap makes addresses below the base fall outside the window too
  assign off     = bus.PrAddr - BASE_ADDR;
  assign in_win  = off < 32'(16 * N_CH);
  assign ch_sel  = off[31:4];
  assign reg_sel = off[3:2];

  logic [N_CH-1:0][31:0] ctrl_rd, preset_rd, count_rd, psc_rd;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    assign hit = bus.PrWe && in_win && (ch_sel == 28'(g));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (hit && reg_sel == REG_CTRL),
      .preset_we (hit && reg_sel == REG_PRESET),
`ifdef TIMER_ARRAY_PRESCALE_EN
      .psc_we    (hit && reg_sel == REG_PSC),
`endif
      .wd        (bus.PrWD),
      .ctrl_rd   (ctrl_rd[g]),
      .preset_rd (preset_rd[g]),
      .count_rd  (count_rd[g]),
      .psc_rd    (psc_rd[g]),
      .irq       (HWInt[g])
    );
  end

  always_comb begin
    bus.PrRD = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_win && ch_sel == 28'(i)) begin
        case (reg_sel)
          REG_CTRL:   bus.PrRD = ctrl_rd[i];
          REG_PRESET: bus.PrRD = preset_rd[i];
          REG_COUNT:  bus.PrRD = count_rd[i];
          default:    bus.PrRD = psc_rd[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// Directed self-checking bench for timer_array (N_CH=2, CNT_W=32).
// Prescale checks run when TIMER_ARRAY_PRESCALE_EN is defined.
module tb_timer_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] hwint;
  int         n_assert = 0;
  int         n_fail   = 0;

  timer_array_if bif ();

  timer_array #(.N_CH(2), .CNT_W(32), .BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif),
    .HWInt (hwint)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the negedge after it
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bif.PrAddr = a;
    bif.PrWD   = d;
    bif.PrWe   = 1'b1;
    @(negedge clk);
    bif.PrWe   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bif.PrAddr = a;
    #1;
    chk(tag, bif.PrRD, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_irq(input logic [1:0] exp, input string tag);
    chk(tag, {30'd0, hwint}, {30'd0, exp});
  endtask

  initial begin
    bif.PrAddr = '0;
    bif.PrWe   = 1'b0;
    bif.PrWD   = '0;
    reset      = 1'b1;
    step(3);
    reset = 1'b0;

    // Reset state
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        rd(32'h7F00 + 32'(16 * c + 4 * r), 32'd0, $sformatf("reset_ch%0d_r%0d", c, r));
    chk_irq(2'b00, "reset_hwint");
    rd(32'h7F20, 32'd0, "out_of_window_rd");
    wr(32'h7F08, 32'h55);
    rd(32'h7F08, 32'd0, "count_wr_ignored");
    wr(32'h7F20, 32'hFF);
    rd(32'h7F20, 32'd0, "oow_wr_ignored");
    rd(32'h7F00, 32'd0, "oow_wr_no_alias");
`ifndef TIMER_ARRAY_PRESCALE_EN
    wr(32'h7F0C, 32'd3);
    rd(32'h7F0C, 32'd0, "psc_absent");
`endif

    // One-shot ch0, PRESET=5, IM=1
    wr(32'h7F04, 32'd5);
    rd(32'h7F04, 32'd5, "preset_rb");
    wr(32'h7F00, 32'h9);
    step(2);
    rd(32'h7F08, 32'd5, "os_count_e2");
    step(5);
    rd(32'h7F08, 32'd0, "os_count_e7");
    chk_irq(2'b00, "os_irq_e7");
    step(1);
    chk_irq(2'b01, "os_irq_e8");
    rd(32'h7F00, 32'h19, "os_ctrl_e8");
    step(1);
    rd(32'h7F00, 32'h18, "os_ctrl_e9");
    step(3);
    chk_irq(2'b01, "os_irq_sticky");
    wr(32'h7F00, 32'h0);
    chk_irq(2'b00, "os_irq_cleared");
    rd(32'h7F00, 32'h0, "os_ctrl_cleared");

    // Auto-reload ch1, PRESET=2: pulses after e5, e10, e15
    wr(32'h7F14, 32'd2);
    wr(32'h7F10, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      logic p;
      step(1);
      p = (k % 5 == 0);
      chk_irq({p, 1'b0}, $sformatf("ar_irq_e%0d", k));
      rd(32'h7F10, {27'd0, p, 4'hB}, $sformatf("ar_ctrl_e%0d", k));
    end
    wr(32'h7F10, 32'h0);

    // Disable mid-count ch0: write lands on the edge that makes COUNT=6
    wr(32'h7F04, 32'd10);
    wr(32'h7F00, 32'h9);
    step(5);
    rd(32'h7F08, 32'd7, "dis_count_e5");
    wr(32'h7F00, 32'h0);
    rd(32'h7F08, 32'd6, "dis_count_e6");
    step(20);
    rd(32'h7F08, 32'd6, "dis_count_held");
    chk_irq(2'b00, "dis_no_irq");

    // Masked one-shot ch0, PRESET=3
    wr(32'h7F04, 32'd3);
    wr(32'h7F00, 32'h1);
    step(6);
    rd(32'h7F00, 32'h11, "mask_ctrl_e6");
    chk_irq(2'b00, "mask_irq_e6");
    step(1);
    rd(32'h7F00, 32'h10, "mask_ctrl_e7");
    chk_irq(2'b00, "mask_irq_e7");
    // Same-edge conflict: CTRL write on the edge entering INT
    wr(32'h7F00, 32'h1);
    step(5);
    wr(32'h7F00, 32'h1);
    rd(32'h7F00, 32'h01, "conflict_ctrl_e6");
    step(1);
    rd(32'h7F00, 32'h00, "conflict_ctrl_e7");
    chk_irq(2'b00, "conflict_irq");

    // Reset mid-count ch1
    wr(32'h7F14, 32'd4);
    wr(32'h7F10, 32'h9);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd(32'h7F10, 32'd0, "rst_ctrl");
    rd(32'h7F14, 32'd0, "rst_preset");
    rd(32'h7F18, 32'd0, "rst_count");
    step(10);
    chk_irq(2'b00, "rst_no_irq");

    // PRESET=0 ch0: interrupt after edge 3
    wr(32'h7F04, 32'd0);
    wr(32'h7F00, 32'h9);
    step(2);
    chk_irq(2'b00, "p0_irq_e2");
    step(1);
    chk_irq(2'b01, "p0_irq_e3");
    wr(32'h7F00, 32'h0);

`ifdef TIMER_ARRAY_PRESCALE_EN
    // Prescale ch1: PSC=3, PRESET=2 -> interrupt after edge 11
    wr(32'h7F1C, 32'd3);
    rd(32'h7F1C, 32'd3, "psc_rb");
    wr(32'h7F14, 32'd2);
    wr(32'h7F10, 32'h9);
    step(2);
    rd(32'h7F18, 32'd2, "psc_count_e2");
    step(3);
    rd(32'h7F18, 32'd2, "psc_count_e5");
    step(1);
    rd(32'h7F18, 32'd1, "psc_count_e6");
    step(4);
    rd(32'h7F18, 32'd0, "psc_count_e10");
    chk_irq(2'b00, "psc_irq_e10");
    step(1);
    chk_irq(2'b10, "psc_irq_e11");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_array.md
# timer_array

Parametrised bank of memory-mapped down-counting timers on the CPU's bridge bus, with one interrupt line per channel feeding the CPU's `HWInt` inputs. It generalises a fixed pair of timers to `N_CH` channels with configurable counter width, one-shot and auto-reload modes, per-channel masking and a sticky pending flag. Bus accesses arrive already address-decoded to the timer window by the bridge.

## Interface
- `N_CH`, 2, number of channels, 1..6, one per available `HWInt` line
- `CNT_W`, 32, counter and preset width, 8..32
- `BASE_ADDR`, 32'h0000_7F00, window base; channel i occupies `BASE_ADDR + 16*i`, 16 bytes
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `PrAddr`  in  32  byte address; bits [1:0] ignored
- `PrWe`  in  1  write strobe, one cycle per write
- `PrWD`  in  32  write data
- `PrRD`  out  32  read data, combinational from `PrAddr`
- `HWInt`  out  N_CH  interrupt lines; bit i = `pend[i] & IM[i]`

## Operation
- Register offsets per channel: 0x0 CTRL, 0x4 PRESET (rw, low `CNT_W` bits), 0x8 COUNT (read-only), 0xC PSC (see Configuration).
- CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as 00), [3] IM, [4] PEND (read-only). All other bits read 0.
- Per-channel FSM, states IDLE, LOAD, CNT, INT.
- IDLE: if EN, go to LOAD. LOAD: `count <= PRESET`, go to CNT.
- CNT: if EN=0, go to IDLE with count held. If count==0, go to INT and set `pend`. Otherwise decrement count.
- INT, MODE 00: clear EN, go to IDLE; `pend` stays set until the next CTRL write.
- INT, MODE 01: go to LOAD; `pend` clears on this edge, giving a one-cycle pulse.
- Any CTRL write clears `pend`. On the same edge, a CTRL write takes precedence over the FSM's own EN or `pend` update.
- A PRESET write during counting has no effect until the next LOAD. Writes to COUNT are ignored.
- Addresses outside the window: reads return 0, writes are ignored.
- With IM=0, `pend` still sets and is visible in CTRL[4], but `HWInt` stays low.

## Timing
- Reset: all registers, count and `pend` go to 0; all states go to IDLE; `HWInt` = 0.
- Cycle reference: CTRL is written with EN=1 on edge e0. Then e1 IDLE→LOAD, e2 count=P, e(2+P) count=0, e(3+P) INT with `pend` set. `HWInt` goes high after edge P+3.
- Auto-reload period: P+3 cycles; pulse width: 1 cycle.
- PRESET=0: interrupt after edge 3.
- Reset asserted mid-count: full reset on that edge, no interrupt.

## Configuration
- `TIMER_ARRAY_PRESCALE_EN` defined: each channel gets an 8-bit PSC register at 0xC and a prescale counter. In CNT, count decrements only on every (PSC+1)-th cycle; the prescale counter clears in LOAD.
- Macro undefined: 0xC reads 0, writes are ignored, and count decrements every cycle.

## Structure
- Package `timer_pkg`: state enum, register offsets, MODE encodings, CTRL bit positions.
- Sub-module `timer_channel`: one FSM plus its registers, instantiated `N_CH` times by a generate loop.
- Top level: address decode and read mux.

## Test plan
- Reset: read every register of every channel → all 0; `HWInt` = 0.
- One-shot, ch0: PRESET=5, CTRL=0b1001 at e0 → `HWInt[0]` rises after e8 and stays high; CTRL reads 0b11000. Writing CTRL=0 drops `HWInt[0]` next cycle.
- Auto-reload, ch1: PRESET=2, CTRL=0b1011 → `HWInt[1]` one-cycle pulses with period 5; PEND=1 only in pulse cycles.
- Disable mid-count: PRESET=10, enable, write CTRL=0 when COUNT=6 → COUNT holds 6, no interrupt.
- Masked with a same-edge conflict: IM=0 one-shot completes → PEND=1, `HWInt`=0. A CTRL write on the edge entering INT leaves PEND=0.
- `TIMER_ARRAY_PRESCALE_EN` defined, PSC=3, PRESET=2 → COUNT decrements every 4 cycles; interrupt after edge 3+4*2.
